// File: rtl/bit_serial_add_sub_ctrl.sv
// rtl/bit_serial_add_sub_ctrl.sv - bit-serial WIDTH-bit adder/subtractor with valid/ready handshakes
// One full-adder cell is stepped over WIDTH cycles, LSB first.

module bit_serial_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_c & (i_a ^ i_b)) | (i_a & i_b);
endmodule

module bit_serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout,
    output logic             io_out_ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum_hold;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_cmsb;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic w_s;
    logic w_c;

    bit_serial_fa u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_sum_hold  <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_cmsb      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_in_valid && r_in_ready) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry.
                        r_a_sh     <= io_in_a;
                        r_b_sh     <= io_in_b ^ {WIDTH{io_in_sub}};
                        r_carry    <= io_in_sub;
                        r_cnt      <= '0;
                        r_sum_hold <= r_sum_sh;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_c;
                    if (r_cnt == LAST) begin
                        r_cmsb      <= r_carry;
                        r_ovf       <= r_carry ^ w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (io_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // sum_sh churns during RUN, so the previous result is shown from a snapshot.
    assign io_out_sum   = (r_state == S_RUN) ? r_sum_hold : r_sum_sh;
    // carry-out is recovered from the carry into the MSB and the overflow flag.
    assign io_out_cout  = r_cmsb ^ r_ovf;
    assign io_out_ovf   = r_ovf;
    assign io_in_ready  = r_in_ready;
    assign io_out_valid = r_out_valid;

endmodule

// File: tb/tb_bit_serial_add_sub_ctrl.sv
// tb/tb_bit_serial_add_sub_ctrl.sv - directed self-checking bench for bit_serial_add_sub_ctrl
`timescale 1ns/1ps

module tb_bit_serial_add_sub_ctrl;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         io_in_valid = 1'b0;
    logic         io_in_ready;
    logic [W-1:0] io_in_a = '0;
    logic [W-1:0] io_in_b = '0;
    logic         io_in_sub = 1'b0;
    logic         io_out_valid;
    logic         io_out_ready = 1'b1;
    logic [W-1:0] io_out_sum;
    logic         io_out_cout;
    logic         io_out_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit_serial_add_sub_ctrl #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_a      (io_in_a),
        .io_in_b      (io_in_b),
        .io_in_sub    (io_in_sub),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_sum   (io_out_sum),
        .io_out_cout  (io_out_cout),
        .io_out_ovf   (io_out_ovf)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after the accept edge; returns the number of edges until valid, or -1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (io_out_valid) begin
                lat = i;
                break;
            end
            @(posedge clock);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] s, output logic c, output logic v);
        logic [W:0] full;
        if (sub) full = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else     full = {1'b0, a} + {1'b0, b};
        s = full[W-1:0];
        c = full[W];
        if (sub) v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else     v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] es, input logic ec, input logic ev);
        int lat;
        @(negedge clock);
        chk({name, "_in_ready"}, io_in_ready, 1);
        io_in_a = a;
        io_in_b = b;
        io_in_sub = sub;
        io_in_valid = 1'b1;
        io_out_ready = 1'b1;
        @(posedge clock);
        wait_valid(lat);
        io_in_valid = 1'b0;
        chk({name, "_latency"}, lat, W);
        chk({name, "_sum"}, io_out_sum, es);
        chk({name, "_cout"}, io_out_cout, ec);
        chk({name, "_ovf"}, io_out_ovf, ev);
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        int prev_acc;
        logic [W-1:0] ms;
        logic mc, mv;

        vecs[0] = '{"add_100_27",  8'd100,  8'd27,  1'b0, 8'd127,  1'b0, 1'b0};
        vecs[1] = '{"add_200_100", 8'd200,  8'd100, 1'b0, 8'd44,   1'b1, 1'b0};
        vecs[2] = '{"add_100_100", 8'd100,  8'd100, 1'b0, 8'd200,  1'b0, 1'b1};
        vecs[3] = '{"sub_5_7",     8'd5,    8'd7,   1'b1, 8'hFE,   1'b0, 1'b0};
        vecs[4] = '{"sub_80_1",    8'h80,   8'd1,   1'b1, 8'h7F,   1'b1, 1'b1};
        vecs[5] = '{"sub_9_9",     8'd9,    8'd9,   1'b1, 8'h00,   1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        chk("rst_in_ready", io_in_ready, 1);
        chk("rst_out_valid", io_out_valid, 0);
        chk("rst_sum", io_out_sum, 0);
        chk("rst_cout", io_out_cout, 0);
        chk("rst_ovf", io_out_ovf, 0);

        // Table-driven add/sub
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // Backpressure: result held under stall, no overlap in DONE
        @(negedge clock);
        io_out_ready = 1'b0;
        io_in_a = 8'h0F;
        io_in_b = 8'h01;
        io_in_sub = 1'b0;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_a = 8'h22;
        io_in_b = 8'h33;
        wait_valid(lat);
        chk("bp_latency", lat, W);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("bp_stall_valid", io_out_valid, 1);
            chk("bp_stall_sum", io_out_sum, 8'h10);
            chk("bp_stall_in_ready", io_in_ready, 0);
        end
        io_out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("bp_release_valid", io_out_valid, 0);
        chk("bp_release_in_ready", io_in_ready, 1);
        @(posedge clock);
        wait_valid(lat);
        io_in_valid = 1'b0;
        chk("bp_next_latency", lat, W);
        chk("bp_next_sum", io_out_sum, 8'h55);
        @(posedge clock);

        // Async reset in the middle of RUN
        @(negedge clock);
        io_in_a = 8'hFF;
        io_in_b = 8'h01;
        io_in_sub = 1'b0;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_in_ready", io_in_ready, 1);
        chk("abort_out_valid", io_out_valid, 0);
        chk("abort_sum", io_out_sum, 0);
        chk("abort_cout", io_out_cout, 0);
        chk("abort_ovf", io_out_ovf, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (io_out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        run_op("post_abort_3_4", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0);

        // Back-to-back with both handshakes held high
        io_out_ready = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (io_in_ready) begin
                    seen = 1;
                    break;
                end
            end
            chk("b2b_ready_seen", seen, 1);
            io_in_a = W'($urandom);
            io_in_b = W'($urandom);
            io_in_sub = k[0];
            io_in_valid = 1'b1;
            if (k > 0) chk("b2b_spacing", cyc - prev_acc, W + 2);
            prev_acc = cyc;
            model(io_in_a, io_in_b, io_in_sub, ms, mc, mv);
            @(posedge clock);
            wait_valid(lat);
            chk("b2b_latency", lat, W);
            chk("b2b_sum", io_out_sum, ms);
            chk("b2b_cout", io_out_cout, mc);
            chk("b2b_ovf", io_out_ovf, mv);
        end
        io_in_valid = 1'b0;
        repeat (2) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
